// File: rtl/mdu_engine.sv
// Multi-cycle multiply/divide engine for the E stage. It produces the HI/LO write data and
// one-cycle write enables, and raises busy while an operation is in flight.
module mdu_engine #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic        HI_we,
    output logic        LO_we
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;

    logic        busy_d, hi_we_d, lo_we_d;
    logic [31:0] hi_d, lo_d;

    // A request is only taken when the engine can start it this edge; flush wins over start.
    logic accept;
    assign accept = start && !flush && (state == IDLE || state == WB);

    // Arithmetic on the latched operands
    logic        sgn, a_neg, b_neg;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    always_comb begin
        sgn   = !op_q[0];
        a_ext = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;
        a_neg = sgn && a_q[31];
        b_neg = sgn && b_q[31];
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
        b_mag = b_neg ? (32'd0 - b_q) : b_q;
        // Magnitude division keeps 0x80000000 / -1 in range: the quotient magnitude 0x80000000 stays positive.
        q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
        quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // State, counter, operand latch and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy   <= 1'b0;
            HI_we  <= 1'b0;
            LO_we  <= 1'b0;
            HI_out <= '0;
            LO_out <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            HI_we  <= hi_we_d;
            LO_we  <= lo_we_d;
            HI_out <= hi_d;
            LO_out <= lo_d;
            if (accept && !op[2]) begin
                op_q <= op[1:0];
                a_q  <= A;
                b_q  <= B;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE, WB: begin
                state_d = IDLE;
                if (accept && !op[2]) begin
                    state_d = RUN;
                    cnt_d   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_d = WB;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_d  = (state_d == RUN);
        hi_we_d = 1'b0;
        lo_we_d = 1'b0;
        hi_d    = HI_out;
        lo_d    = LO_out;
        if (state == RUN && state_d == WB) begin
            if (!op_q[1]) begin
                hi_we_d = 1'b1;
                lo_we_d = 1'b1;
                hi_d    = prod[63:32];
                lo_d    = prod[31:0];
            end else if (b_q != '0) begin
                hi_we_d = 1'b1;
                lo_we_d = 1'b1;
                hi_d    = rem;
                lo_d    = quo;
            end
        end
        if (accept && op == 3'd4) begin
            hi_we_d = 1'b1;
            hi_d    = A;
        end
        if (accept && op == 3'd5) begin
            lo_we_d = 1'b1;
            lo_d    = A;
        end
    end

endmodule

// File: tb/tb_mdu_engine.sv
// Self-checking bench for mdu_engine: directed vector table, hand-written flush/reset
// sequences, and random operations checked against a plain-arithmetic reference model.
module tb_mdu_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        flush;
    logic        busy;
    logic [31:0] HI_out, LO_out;
    logic        HI_we, LO_we;

    int passed = 0;
    int total  = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mdu_engine #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .flush(flush),
        .busy(busy), .HI_out(HI_out), .LO_out(LO_out), .HI_we(HI_we), .LO_we(LO_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hwe;
        logic        lwe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        else
            passed++;
    endtask

    function automatic int exp_busy(input logic [2:0] o);
        if (o <= 3'd1) return 5;
        if (o <= 3'd3) return 10;
        return 0;
    endfunction

    // Reference model straight from the ISA definition of each operation
    task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo,
                             output logic hwe, output logic lwe);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        hi = model_hi; lo = model_lo; hwe = 1'b0; lwe = 1'b0;
        sa = a; sb = b;
        case (o)
            3'd0: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; hwe = 1; lwe = 1; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; hwe = 1; lwe = 1; end
            3'd2: if (b != 0) begin
                hwe = 1; lwe = 1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            3'd3: if (b != 0) begin lo = a / b; hi = a % b; hwe = 1; lwe = 1; end
            3'd4: begin hi = a; hwe = 1; end
            3'd5: begin lo = a; lwe = 1; end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ehw, input logic elw, input string name);
        int nb;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0;
        @(negedge clk);
        while (busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, nb, exp_busy(o));
        check({name, " HI_we"}, {31'd0, HI_we}, {31'd0, ehw});
        check({name, " LO_we"}, {31'd0, LO_we}, {31'd0, elw});
        check({name, " HI_out"}, HI_out, eh);
        check({name, " LO_out"}, LO_out, el);
        @(negedge clk);
        check({name, " we_drop"}, {30'd0, HI_we, LO_we}, 32'd0);
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        int activity;
        logic [31:0] rh, rl;
        logic rhw, rlw;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1, 1};
        vecs[1] = '{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1, 1};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1};
        vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1, 1};
        vecs[4] = '{3'd2, 32'd5,         32'd0,         32'h0000_0000, 32'h8000_0000, 0, 0};
        vecs[5] = '{3'd5, 32'h1234_5678, 32'd0,         32'h0000_0000, 32'h1234_5678, 0, 1};
        vecs[6] = '{3'd4, 32'h9ABC_DEF0, 32'd0,         32'h9ABC_DEF0, 32'h1234_5678, 1, 0};
        vecs[7] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1, 1};
        vecs[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1, 1};

        reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; flush = 1'b0;
        #7;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset we", {30'd0, HI_we, LO_we}, 32'd0);
        check("reset HI_out", HI_out, 32'd0);
        check("reset LO_out", LO_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].hwe, vecs[i].lwe, $sformatf("vec%0d", i));

        // Reserved op is ignored
        @(negedge clk);
        issue(3'd6, 32'hDEAD_BEEF, 32'd3);
        activity = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || HI_we || LO_we) activity++;
        end
        check("reserved activity", activity, 0);
        check("reserved HI_out", HI_out, model_hi);
        check("reserved LO_out", LO_out, model_lo);

        // Flush together with an MT start in IDLE drops the start
        @(negedge clk);
        flush = 1'b1;
        issue(3'd4, 32'h5555_5555, 32'd0);
        flush = 1'b0;
        @(negedge clk);
        check("flush+mt HI_we", {31'd0, HI_we}, 32'd0);
        check("flush+mt HI_out", HI_out, model_hi);

        // MULTU, DIVU dropped while busy, flush drops the operation
        @(negedge clk);
        issue(3'd1, 32'd1000, 32'd1000);
        @(negedge clk);
        check("flush seq busy1", {31'd0, busy}, 32'd1);
        issue(3'd3, 32'd50, 32'd5);
        @(negedge clk);
        check("flush seq busy3", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush seq busy_drop", {31'd0, busy}, 32'd0);
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || HI_we || LO_we) activity++;
        end
        check("flush seq no_activity", activity, 0);
        check("flush seq HI_out", HI_out, model_hi);
        run_op(3'd0, 32'd12345, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_9F8E, 1, 1, "post_flush mult");

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        issue(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst we", {30'd0, HI_we, LO_we}, 32'd0);
        check("async rst HI_out", HI_out, 32'd0);
        check("async rst LO_out", LO_out, 32'd0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        activity = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy || HI_we || LO_we) activity++;
        end
        check("post rst no_activity", activity, 0);

        // MULT followed by MTHI issued in the WB cycle
        issue(3'd0, 32'd7, 32'd6);
        activity = 0;
        @(negedge clk);
        while (busy && activity < 40) begin
            activity++;
            @(negedge clk);
        end
        check("b2b mult busy_cycles", activity, 5);
        check("b2b mult we", {30'd0, HI_we, LO_we}, 32'd3);
        check("b2b mult LO_out", LO_out, 32'd42);
        check("b2b mult HI_out", HI_out, 32'd0);
        issue(3'd4, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        check("b2b mthi HI_we", {31'd0, HI_we}, 32'd1);
        check("b2b mthi LO_we", {31'd0, LO_we}, 32'd0);
        check("b2b mthi HI_out", HI_out, 32'hCAFE_F00D);
        check("b2b mthi LO_out", LO_out, 32'd42);
        check("b2b mthi busy", {31'd0, busy}, 32'd0);
        model_hi = 32'hCAFE_F00D; model_lo = 32'd42;

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            ref_model(ro, ra, rb, rh, rl, rhw, rlw);
            run_op(ro, ra, rb, rh, rl, rhw, rlw, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
